// File: rtl/ddr3_rx_dq_train_align.sv
// Read-path trainer for one DDR3 DQ lane: sweeps the IOD delay line against a
// known pattern, centres on the first wide-enough eye, bit-slips to word
// alignment, then forwards aligned read data.
module ddr3_rx_dq_train_align #(
  parameter int unsigned TAP_WIDTH     = 7,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_WORDS  = 16,
  parameter logic [3:0]  TRAIN_PATTERN = 4'b1010,
  parameter int unsigned MIN_WINDOW    = 4
) (
  input  logic                 FAB_CLK,
  input  logic                 RESET_N,
  input  logic                 TRAIN_START,
  input  logic [3:0]           RX_DATA_0,
  input  logic                 DELAY_LINE_OUT_OF_RANGE_0,
  output logic                 DELAY_LINE_LOAD_0,
  output logic                 DELAY_LINE_MOVE_0,
  output logic                 DELAY_LINE_DIRECTION_0,
  output logic                 RX_BIT_SLIP_0,
  output logic [TAP_WIDTH-1:0] TAP_VALUE,
  output logic [1:0]           SLIP_COUNT,
  output logic                 TRAIN_DONE,
  output logic                 TRAIN_ERR,
  output logic [3:0]           RX_DATA_OUT,
  output logic                 RX_VALID
);

  localparam int unsigned WIN_W = TAP_WIDTH + 1;
  localparam int unsigned CNT_W = TAP_WIDTH + 2 + $clog2(SETTLE_CYCLES + SAMPLE_WORDS + 2);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_STEP,
    ST_CENTER, ST_SLIP_CHK, ST_SLIP_WAIT, ST_DONE, ST_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0] tap_q, tap_d;
  logic [TAP_WIDTH-1:0] first_q, first_d, last_q, last_d;
  logic [TAP_WIDTH-1:0] target_q, target_d;
  logic [TAP_WIDTH-1:0] win_first, win_last, open_first;
  logic [WIN_W-1:0]     win_sum, run_len, open_len;
  logic [CNT_W-1:0]     center_end;
  logic                 run_q, run_d, pass_q, pass_d, pass_now, to_center;
  logic [1:0]           slip_q, slip_d;
  logic                 load_q, load_d, move_q, move_d, dir_q, dir_d;
  logic                 bitslip_q, bitslip_d, done_q, done_d, err_q, err_d;
  logic                 valid_q, valid_d;
  logic [3:0]           rx_q;

  // A word passes the sweep if it is any rotation of the training pattern
  function automatic logic is_rot(input logic [3:0] w);
    return (w == TRAIN_PATTERN) ||
           (w == {TRAIN_PATTERN[0],   TRAIN_PATTERN[3:1]}) ||
           (w == {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]}) ||
           (w == {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]});
  endfunction

  assign pass_now   = pass_q && is_rot(RX_DATA_0);
  assign run_len    = {1'b0, last_q} - {1'b0, first_q} + WIN_W'(1);
  assign open_first = run_q ? first_q : tap_q;
  assign open_len   = {1'b0, tap_q} - {1'b0, open_first} + WIN_W'(1);
  assign center_end = CNT_W'({target_q, 1'b0}) + CNT_W'(SETTLE_CYCLES);

  // Next-state, window tracking and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    run_d     = run_q;
    first_d   = first_q;
    last_d    = last_q;
    target_d  = target_q;
    slip_d    = slip_q;
    win_first = first_q;
    win_last  = last_q;
    win_sum   = '0;
    to_center = 1'b0;
    tap_d     = tap_q;
    if (load_q)      tap_d = '0;
    else if (move_q) tap_d = tap_q + TAP_WIDTH'(1);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (TRAIN_START) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
        run_d   = 1'b0;
        first_d = '0;
        last_d  = '0;
        slip_d  = '0;
      end
      ST_SETTLE: begin
        if (DELAY_LINE_OUT_OF_RANGE_0) begin
          // Out-of-range tap counts as failed and ends the sweep
          if (run_q && (run_len >= WIN_W'(MIN_WINDOW))) to_center = 1'b1;
          else                                          state_d   = ST_ERR;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
          pass_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (cnt_q != CNT_W'(SAMPLE_WORDS - 1)) begin
          pass_d = pass_now;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (pass_now) begin
          win_first = open_first;
          win_last  = tap_q;
          first_d   = open_first;
          last_d    = tap_q;
          run_d     = 1'b1;
          if (tap_q == TAP_MAX) begin
            if (open_len >= WIN_W'(MIN_WINDOW)) to_center = 1'b1;
            else                                state_d   = ST_ERR;
          end else begin
            state_d = ST_STEP;
          end
        end else if (run_q && (run_len >= WIN_W'(MIN_WINDOW))) begin
          to_center = 1'b1;
        end else begin
          run_d   = 1'b0;
          state_d = (tap_q == TAP_MAX) ? ST_ERR : ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_CENTER: begin
        if (cnt_q == center_end) begin
          state_d = ST_SLIP_CHK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SLIP_CHK: begin
        if (RX_DATA_0 == TRAIN_PATTERN) begin
          state_d = ST_DONE;
        end else if (slip_q == 2'd3) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_SLIP_WAIT;
          slip_d  = slip_q + 2'd1;
          cnt_d   = '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_SLIP_CHK;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_center) begin
      state_d  = ST_CENTER;
      cnt_d    = '0;
      win_sum  = {1'b0, win_first} + {1'b0, win_last};
      target_d = win_sum[WIN_W-1:1];
    end

    // CENTER: cnt 0 = LOAD, odd cnt up to 2*target = MOVE, then settle
    load_d    = (state_d == ST_LOAD) || ((state_d == ST_CENTER) && (cnt_d == '0));
    move_d    = (state_d == ST_STEP) ||
                ((state_d == ST_CENTER) && cnt_d[0] && (cnt_d <= CNT_W'({target_d, 1'b0})));
    bitslip_d = (state_q == ST_SLIP_CHK) && (state_d == ST_SLIP_WAIT);
    dir_d     = state_d inside {ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_STEP, ST_CENTER};
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
    valid_d   = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tap_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      target_q  <= '0;
      run_q     <= 1'b0;
      pass_q    <= 1'b0;
      slip_q    <= '0;
      load_q    <= 1'b0;
      move_q    <= 1'b0;
      dir_q     <= 1'b0;
      bitslip_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      rx_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      first_q   <= first_d;
      last_q    <= last_d;
      target_q  <= target_d;
      run_q     <= run_d;
      pass_q    <= pass_d;
      slip_q    <= slip_d;
      load_q    <= load_d;
      move_q    <= move_d;
      dir_q     <= dir_d;
      bitslip_q <= bitslip_d;
      done_q    <= done_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      rx_q      <= RX_DATA_0;
    end
  end

  assign DELAY_LINE_LOAD_0      = load_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign RX_BIT_SLIP_0          = bitslip_q;
  assign TAP_VALUE              = tap_q;
  assign SLIP_COUNT             = slip_q;
  assign TRAIN_DONE             = done_q;
  assign TRAIN_ERR              = err_q;
  assign RX_DATA_OUT            = rx_q;
  assign RX_VALID               = valid_q;

endmodule

// File: tb/tb_ddr3_rx_dq_train_align.sv
// Bench for ddr3_rx_dq_train_align: an IOD model that passes/fails words by
// tap, a table of eye scenarios, and hand sequences for reset and restart.
module tb_ddr3_rx_dq_train_align;

  logic       clk, rst_n, start;
  logic [3:0] rx_data;
  logic       oor;
  logic       dl_load, dl_move, dl_dir, bit_slip;
  logic [4:0] tap_value;
  logic [1:0] slip_count;
  logic       done, err, rx_valid;
  logic [3:0] rx_out;

  ddr3_rx_dq_train_align #(
    .TAP_WIDTH(5), .SETTLE_CYCLES(2), .SAMPLE_WORDS(4),
    .TRAIN_PATTERN(4'b1010), .MIN_WINDOW(4)
  ) dut (
    .FAB_CLK(clk), .RESET_N(rst_n), .TRAIN_START(start),
    .RX_DATA_0(rx_data), .DELAY_LINE_OUT_OF_RANGE_0(oor),
    .DELAY_LINE_LOAD_0(dl_load), .DELAY_LINE_MOVE_0(dl_move),
    .DELAY_LINE_DIRECTION_0(dl_dir), .RX_BIT_SLIP_0(bit_slip),
    .TAP_VALUE(tap_value), .SLIP_COUNT(slip_count),
    .TRAIN_DONE(done), .TRAIN_ERR(err),
    .RX_DATA_OUT(rx_out), .RX_VALID(rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Eye scenario: passing taps [lo1,hi1] and [lo2,hi2], out-of-range from oor_tap
  typedef struct {
    int lo1; int hi1; int lo2; int hi2; int oor_tap; int mode;
    int exp_tap; int exp_slip; int exp_done; int exp_max; int exp_loads; int exp_slips;
  } vec_t;

  vec_t cfg;
  vec_t vecs[11];

  // IOD model state
  int         iod_tap = 0, iod_slip = 0, max_tap = 0, cyc = 0;
  int         n_load = 0, n_move = 0, n_slip = 0;
  logic       prev_move = 1'b0;
  logic [3:0] rx_drv = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic tap_pass(input int t);
    return (t >= cfg.lo1 && t <= cfg.hi1) || (t >= cfg.lo2 && t <= cfg.hi2);
  endfunction

  function automatic logic [3:0] iod_word();
    logic [3:0] pw;
    if (cfg.mode == 0)      pw = 4'b1010;
    else if (cfg.mode == 1) pw = (iod_slip >= 1) ? 4'b1010 : 4'b0101;
    else                    pw = 4'b0101;
    if (tap_pass(iod_tap)) return pw;
    return ((cyc % 4) == 0) ? 4'b1110 : 4'b1010;
  endfunction

  // IOD model plus per-cycle checks of data delay and pulse legality
  always @(posedge clk) begin
    #1;
    chk("rx_data_out", int'(rx_out), rst_n ? int'(rx_drv) : 0);
    if (!rst_n) begin
      iod_tap = 0; iod_slip = 0; max_tap = 0;
      n_load = 0; n_move = 0; n_slip = 0; prev_move = 1'b0;
    end else begin
      if (dl_load || dl_move || bit_slip) begin
        chk("pulse_legal",
            int'((int'(dl_load) + int'(dl_move) + int'(bit_slip)) == 1 &&
                 (!(dl_load || dl_move) || dl_dir) && !(dl_move && prev_move)), 1);
      end
      if (dl_load)  begin iod_tap = 0; n_load++; end
      if (dl_move)  begin iod_tap++;   n_move++; end
      if (bit_slip) begin iod_slip++;  n_slip++; end
      if (iod_tap > max_tap) max_tap = iod_tap;
      prev_move = dl_move;
    end
    cyc++;
    rx_drv  = iod_word();
    rx_data = rx_drv;
    oor     = (iod_tap >= cfg.oor_tap);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(done || err), 1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outs"},
        int'({dl_load, dl_move, dl_dir, bit_slip, tap_value, slip_count,
              done, err, rx_out, rx_valid}), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_data = 4'h0; oor = 1'b0;
    cfg = '{99, -1, 99, -1, 99, 0, 0, 0, 0, 0, 0, 0};

    //         lo1 hi1 lo2 hi2 oor mode tap slip done max loads slips
    vecs[0]  = '{10, 20, 99, -1, 99, 0, 15, 0, 1, 21, 2, 0}; // clean eye
    vecs[1]  = '{ 3,  4, 10, 25, 99, 0, 17, 0, 1, 26, 2, 0}; // short run discarded
    vecs[2]  = '{ 8, 15, 99, -1, 99, 1, 11, 1, 1, 16, 2, 1}; // one slip aligns
    vecs[3]  = '{ 8, 15, 99, -1, 99, 2, 11, 3, 0, 16, 2, 3}; // never aligns
    vecs[4]  = '{99, -1, 99, -1, 99, 0, 31, 0, 0, 31, 1, 0}; // no eye
    vecs[5]  = '{12, 31, 99, -1, 20, 0, 15, 0, 1, 20, 2, 0}; // out of range closes window
    vecs[6]  = '{ 5,  8, 99, -1, 99, 0,  6, 0, 1,  9, 2, 0}; // exactly MIN_WINDOW
    vecs[7]  = '{ 5,  7, 99, -1, 99, 0, 31, 0, 0, 31, 1, 0}; // MIN_WINDOW-1 only
    vecs[8]  = '{28, 31, 99, -1, 99, 0, 29, 0, 1, 31, 2, 0}; // run open at max tap
    vecs[9]  = '{12, 31, 99, -1, 14, 0, 14, 0, 0, 14, 1, 0}; // out of range, run too short
    vecs[10] = '{ 0,  5, 99, -1, 99, 0,  2, 0, 1,  6, 2, 0}; // eye from tap 0

    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cfg = vecs[i];
      do_reset();
      pulse_start();
      wait_end($sformatf("v%0d_end", i));
      chk($sformatf("v%0d_tap", i),   int'(tap_value),  cfg.exp_tap);
      chk($sformatf("v%0d_slip", i),  int'(slip_count), cfg.exp_slip);
      chk($sformatf("v%0d_done", i),  int'(done),       cfg.exp_done);
      chk($sformatf("v%0d_err", i),   int'(err),        1 - cfg.exp_done);
      chk($sformatf("v%0d_valid", i), int'(rx_valid),   cfg.exp_done);
      chk($sformatf("v%0d_maxtap", i), max_tap,         cfg.exp_max);
      chk($sformatf("v%0d_loads", i), n_load,           cfg.exp_loads);
      chk($sformatf("v%0d_slips", i), n_slip,           cfg.exp_slips);
    end

    // Reset in the middle of SAMPLE at tap 9
    cfg = vecs[0];
    do_reset();
    pulse_start();
    begin
      int n = 0;
      while (tap_value != 5'd9 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("reach_tap9", int'(tap_value), 9);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_reset_no_load", n_load, 0);

    // Start coinciding with reset is dropped
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check_all_zero("start_in_reset");
    repeat (4) @(negedge clk);
    chk("start_in_reset_loads", n_load, 0);

    // Full training after the reset
    pulse_start();
    wait_end("retrain_end");
    chk("retrain_tap", int'(tap_value), 15);
    chk("retrain_done", int'(done), 1);
    chk("retrain_loads", n_load, 2);

    // Restart from DONE: flags drop on the cycle after the accepted start
    pulse_start();
    chk("restart_done_clr", int'(done), 0);
    chk("restart_valid_clr", int'(rx_valid), 0);
    chk("restart_load", int'(dl_load), 1);
    repeat (20) @(negedge clk);
    pulse_start(); // ignored mid-sweep
    wait_end("restart_end");
    chk("restart_tap", int'(tap_value), 15);
    chk("restart_done", int'(done), 1);
    chk("restart_loads", n_load, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
